// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM encoding, NOP, and the opcodes
// decoded by pc_ctrl_sel.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int REDIRECT_CNT_W = 16;

  // Saturating increment for the redirect performance counter
  function automatic logic [REDIRECT_CNT_W-1:0] sat_inc(
      input logic [REDIRECT_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline latch: load enable, plus a synchronous flush that turns the
// held instruction into a NOP while leaving the recorded PC alone.
module ifid_reg
  import proc_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int INSN_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [INSN_W-1:0] insn_d,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic              valid_d,
  output logic [INSN_W-1:0] ifid_insn,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid
);

  logic [INSN_W-1:0] insn_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              valid_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      insn_reg  <= INSN_W'(NOP_INSN);
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      insn_reg  <= INSN_W'(NOP_INSN);
      valid_reg <= 1'b0;
    end else if (load) begin
      insn_reg  <= insn_d;
      pc_reg    <= pc_d;
      valid_reg <= valid_d;
    end
  end

  assign ifid_insn  = insn_reg;
  assign ifid_pc    = pc_reg;
  assign ifid_valid = valid_reg;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, RUN/FLUSH/HALT control, IF/ID latch
// loading, and a saturating count of taken redirects.
module pc_fetch
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_q,
  input  logic              stall,
  input  logic              pc_sel,
  input  logic              take,
  input  logic [ADDR_W-1:0] target,
  input  logic              halt,
  output logic [INSN_W-1:0] ifid_insn,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic [15:0]       redirect_cnt,
  output logic              halted
);

  fetch_state_t                state_reg, state_next;
  logic [ADDR_W-1:0]           pc_reg, pc_next;
  logic [REDIRECT_CNT_W-1:0]   cnt_reg, cnt_next;
  logic                        halted_reg;

  logic              redirect;
  logic [ADDR_W-1:0] pc_plus1;
  logic              ifid_load;
  logic              ifid_flush;
  logic [INSN_W-1:0] ifid_insn_d;
  logic [ADDR_W-1:0] ifid_pc_d;
  logic              ifid_valid_d;

  assign redirect = pc_sel & take;
  assign pc_plus1 = pc_reg + ADDR_W'(1);

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    cnt_next     = cnt_reg;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_insn_d  = imem_q;
    ifid_pc_d    = pc_plus1;
    ifid_valid_d = 1'b1;

    case (state_reg)
      ST_RUN, ST_FLUSH: begin
        if (halt) begin
          // Halt beats a same-edge redirect; the redirect is dropped uncounted
          state_next = ST_HALT;
          ifid_flush = 1'b1;
        end else if (redirect) begin
          state_next   = ST_FLUSH;
          pc_next      = target;
          cnt_next     = sat_inc(cnt_reg);
          ifid_load    = 1'b1;
          ifid_insn_d  = INSN_W'(NOP_INSN);
          ifid_pc_d    = '0;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          state_next = ST_RUN;
          pc_next    = pc_plus1;
          ifid_load  = 1'b1;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= ST_RUN;
      pc_reg     <= RESET_PC;
      cnt_reg    <= '0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      cnt_reg    <= cnt_next;
      halted_reg <= (state_next == ST_HALT);
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W),
    .INSN_W (INSN_W)
  ) u_ifid_reg (
    .clock      (clock),
    .reset      (reset),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .insn_d     (ifid_insn_d),
    .pc_d       (ifid_pc_d),
    .valid_d    (ifid_valid_d),
    .ifid_insn  (ifid_insn),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid)
  );

  assign imem_addr    = pc_reg;
  assign redirect_cnt = cnt_reg;
  assign halted       = halted_reg;

endmodule
